// File: rtl/riscv_pkg.sv
// Shared encodings for the single-cycle RV32I-subset core: opcodes, funct fields,
// ALU operation enum and the ALU evaluation helper.
package riscv_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [6:0] F7_ALT = 7'b0100000;

    localparam logic [31:0] NOP = 32'h00000013;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
        ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA
    } alu_op_e;

    // alt selects SUB/SRA; callers only raise it where the encoding allows it.
    function automatic alu_op_e alu_op_from_f3(input logic [2:0] f3, input logic alt);
        case (f3)
            F3_ADD_SUB: return alt ? ALU_SUB : ALU_ADD;
            F3_SLL:     return ALU_SLL;
            F3_SLT:     return ALU_SLT;
            F3_SLTU:    return ALU_SLTU;
            F3_XOR:     return ALU_XOR;
            F3_SRL_SRA: return alt ? ALU_SRA : ALU_SRL;
            F3_OR:      return ALU_OR;
            default:    return ALU_AND;
        endcase
    endfunction

    function automatic logic [31:0] alu_eval(input alu_op_e op, input logic [31:0] a,
                                             input logic [31:0] b);
        case (op)
            ALU_SUB:  return a - b;
            ALU_AND:  return a & b;
            ALU_OR:   return a | b;
            ALU_XOR:  return a ^ b;
            ALU_SLT:  return {31'b0, $signed(a) < $signed(b)};
            ALU_SLTU: return {31'b0, a < b};
            ALU_SLL:  return a << b[4:0];
            ALU_SRL:  return a >> b[4:0];
            ALU_SRA:  return 32'($signed(a) >>> b[4:0]);
            default:  return a + b;
        endcase
    endfunction

endpackage

// File: rtl/riscv_regfile.sv
// 32x32 register file, two combinational read ports, one write port, x0 hardwired to zero.
module riscv_regfile (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  raddr1_i,
    input  logic [4:0]  raddr2_i,
    input  logic [4:0]  waddr_i,
    input  logic        we_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata1_o,
    output logic [31:0] rdata2_o
);

    logic [31:0] regs_q [32];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) regs_q[i] <= '0;
        end else if (we_i && (waddr_i != 5'd0)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    // Reads see the pre-edge contents, so a same-cycle write is not forwarded.
    assign rdata1_o = (raddr1_i == 5'd0) ? '0 : regs_q[raddr1_i];
    assign rdata2_o = (raddr2_i == 5'd0) ? '0 : regs_q[raddr2_i];

endmodule

// File: rtl/riscv_processor.sv
// Single-cycle RV32I-subset core: ROM fetch, decode, ALU, writeback and PC update
// all complete in one clock; unsupported opcodes behave as NOP.
module riscv_processor
    import riscv_pkg::*;
#(
    parameter int          IMEM_DEPTH = 64,
    parameter logic [31:0] RESET_PC   = 32'h00000000,
    // Boot program, word 0 in the low 32 bits; the rest of the ROM holds NOP.
    parameter logic [127:0] PROG_INIT = {32'h403101b3, 32'h002081b3,
                                         32'h00600113, 32'h00500093}
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] pc_out,
    output logic [31:0] instruction_out
);

    localparam int          AW         = $clog2(IMEM_DEPTH);
    localparam logic [31:0] IMEM_BYTES = 32'(4 * IMEM_DEPTH);

    logic [31:0] pc_q, pc_d, pc_plus4;
    logic [31:0] instr;
    logic [AW-1:0] rom_idx;

    logic [6:0]  opcode, f7;
    logic [2:0]  f3;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm_i, imm_b, imm_j, imm_u;
    logic [31:0] rs1_data, rs2_data;
    logic [31:0] op_b, alu_res, wb_data;
    alu_op_e     alu_op;
    logic        reg_we, taken;

    always_comb begin
        rom_idx = pc_q[AW+1:2];
        if (pc_q >= IMEM_BYTES)    instr = NOP;
        else if (int'(rom_idx) < 4) instr = PROG_INIT[32*int'(rom_idx) +: 32];
        else                        instr = NOP;
    end

    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign f3     = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign f7     = instr[31:25];

    assign imm_i = {{21{instr[31]}}, instr[30:20]};
    assign imm_b = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_j = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};

    riscv_regfile u_regfile (
        .clk      (clk),
        .reset    (reset),
        .raddr1_i (rs1),
        .raddr2_i (rs2),
        .waddr_i  (rd),
        .we_i     (reg_we),
        .wdata_i  (wb_data),
        .rdata1_o (rs1_data),
        .rdata2_o (rs2_data)
    );

    always_comb begin
        taken = 1'b0;
        case (f3)
            F3_BEQ:  taken = (rs1_data == rs2_data);
            F3_BNE:  taken = (rs1_data != rs2_data);
            F3_BLT:  taken = ($signed(rs1_data) <  $signed(rs2_data));
            F3_BGE:  taken = ($signed(rs1_data) >= $signed(rs2_data));
            F3_BLTU: taken = (rs1_data <  rs2_data);
            F3_BGEU: taken = (rs1_data >= rs2_data);
            default: taken = 1'b0;
        endcase
    end

    assign pc_plus4 = pc_q + 32'd4;
    assign alu_res  = alu_eval(alu_op, rs1_data, op_b);

    always_comb begin
        alu_op  = ALU_ADD;
        op_b    = imm_i;
        reg_we  = 1'b0;
        wb_data = alu_res;
        pc_d    = pc_plus4;
        case (opcode)
            OPC_OP: begin
                alu_op = alu_op_from_f3(f3, f7 == F7_ALT);
                op_b   = rs2_data;
                reg_we = 1'b1;
            end
            OPC_OP_IMM: begin
                // ADDI immediates may set bit 30, so only shifts honour the alt bit.
                alu_op = alu_op_from_f3(f3, (f3 == F3_SRL_SRA) && (f7 == F7_ALT));
                reg_we = 1'b1;
            end
            OPC_LUI: begin
                reg_we  = 1'b1;
                wb_data = imm_u;
            end
            OPC_AUIPC: begin
                reg_we  = 1'b1;
                wb_data = pc_q + imm_u;
            end
            OPC_BRANCH: pc_d = taken ? (pc_q + imm_b) : pc_plus4;
            OPC_JAL: begin
                reg_we  = 1'b1;
                wb_data = pc_plus4;
                pc_d    = pc_q + imm_j;
            end
            OPC_JALR: begin
                reg_we  = 1'b1;
                wb_data = pc_plus4;
                pc_d    = {alu_res[31:1], 1'b0};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) pc_q <= RESET_PC;
        else       pc_q <= pc_d;
    end

    assign pc_out          = pc_q;
    assign instruction_out = instr;

endmodule

// File: tb/tb_riscv_processor.sv
// Directed bench for riscv_processor: boot program, reset behaviour, x0, branch,
// JAL and ROM-end fetch, with a pc/instruction scoreboard.
module tb_riscv_processor;

    logic clk = 1'b0;
    logic rst_main, rst_aux;
    always #5 clk = ~clk;

    logic [31:0] pc_m, in_m, pc_x0, in_x0, pc_br, in_br, pc_jal, in_jal;

    riscv_processor dut (
        .clk(clk), .reset(rst_main), .pc_out(pc_m), .instruction_out(in_m)
    );
    // ADDI x0,x0,7 ; ADDI x1,x0,1
    riscv_processor #(.PROG_INIT({32'h00000013, 32'h00000013, 32'h00100093, 32'h00700013}))
    dut_x0 (
        .clk(clk), .reset(rst_aux), .pc_out(pc_x0), .instruction_out(in_x0)
    );
    // ADDI ; ADDI ; BEQ x0,x0,-8 at 0x8
    riscv_processor #(.PROG_INIT({32'h00000013, 32'hfe000ce3, 32'h00600113, 32'h00500093}))
    dut_br (
        .clk(clk), .reset(rst_aux), .pc_out(pc_br), .instruction_out(in_br)
    );
    // JAL x1,+12 at 0x0
    riscv_processor #(.PROG_INIT({32'h00000013, 32'h00000013, 32'h00000013, 32'h00c000ef}))
    dut_jal (
        .clk(clk), .reset(rst_aux), .pc_out(pc_jal), .instruction_out(in_jal)
    );

    localparam logic [31:0] NOP_W = 32'h00000013;

    int checks = 0;
    int failures = 0;
    logic [63:0] exp_q[$];
    logic [31:0] br_q[$];
    logic [31:0] jal_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_main(input logic [31:0] pc, input logic [31:0] ins);
        exp_q.push_back({pc, ins});
    endtask

    task automatic push_program();
        push_main(32'h0, 32'h00500093);
        push_main(32'h4, 32'h00600113);
        push_main(32'h8, 32'h002081b3);
        push_main(32'hC, 32'h403101b3);
    endtask

    // Compare the current cycle against the scoreboards, then advance one clock.
    task automatic step();
        logic [63:0] e;
        logic [31:0] p;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL sb_underflow observed=%h expected=none", pc_m);
        end else begin
            e = exp_q.pop_front();
            check("pc", pc_m, e[63:32]);
            check("instr", in_m, e[31:0]);
        end
        if (br_q.size() != 0) begin
            p = br_q.pop_front();
            check("br_pc", pc_br, p);
        end
        if (jal_q.size() != 0) begin
            p = jal_q.pop_front();
            check("jal_pc", pc_jal, p);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_prog_regs(input string tag);
        check({tag, "_x1"}, dut.u_regfile.regs_q[1], 32'd5);
        check({tag, "_x2"}, dut.u_regfile.regs_q[2], 32'd6);
        check({tag, "_x3"}, dut.u_regfile.regs_q[3], 32'hFFFFFFFB);
    endtask

    task automatic check_regs_zero(input string tag);
        for (int i = 1; i < 32; i++) check(tag, dut.u_regfile.regs_q[i], 32'd0);
    endtask

    initial begin
        rst_main = 1'b1;
        rst_aux  = 1'b1;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            check("rst_pc", pc_m, 32'h0);
            check("rst_instr", in_m, 32'h00500093);
        end
        rst_main = 1'b0;
        rst_aux  = 1'b0;
        #1;
        check("release_pc", pc_m, 32'h0);

        push_program();
        br_q  = '{32'h0, 32'h4, 32'h8, 32'h0, 32'h4};
        jal_q = '{32'h0, 32'hC, 32'h10, 32'h14};
        repeat (4) step();
        check_prog_regs("boot");
        check("x0_stays_zero", dut_x0.u_regfile.regs_q[0], 32'd0);
        check("x0_reads_zero", dut_x0.u_regfile.regs_q[1], 32'd1);
        check("jal_link", dut_jal.u_regfile.regs_q[1], 32'h4);

        for (int i = 0; i < 6; i++) push_main(32'h10 + 32'(4 * i), NOP_W);
        repeat (6) step();
        check_prog_regs("after_nops");

        rst_main = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst_main = 1'b0;
        check("reset1_pc", pc_m, 32'h0);
        check_regs_zero("reset1_reg");

        push_program();
        push_main(32'h10, NOP_W);
        push_main(32'h14, NOP_W);
        repeat (6) step();
        check("pre_reset_pc", pc_m, 32'h18);
        rst_main = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst_main = 1'b0;
        check("midreset_pc", pc_m, 32'h0);
        check_regs_zero("midreset_reg");

        push_program();
        repeat (4) step();
        check_prog_regs("rerun");

        // Walk past the end of the 64-word ROM; fetches there must be NOP.
        for (int a = 'h10; a <= 'h108; a += 4) push_main(32'(a), NOP_W);
        while (exp_q.size() != 0) step();
        check("past_rom_pc", pc_m, 32'h10C);
        check("past_rom_instr", in_m, NOP_W);
        check_prog_regs("end");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
